alt_rom_sin_cos_arbiter: RTL and testbench

//  Shares one alt_rom_sin_cos lookup among CHANNELS independent requesters.

---
 rtl/alt_rom_sin_cos_arbiter.sv | 136 +++++++++++++
 tb/tb_alt_rom_sin_cos_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alt_rom_sin_cos_arbiter.sv
// -----------------------------------------------------------------------------
// alt_rom_sin_cos_arbiter
// Shares one sin/cos lookup ROM among CHANNELS requesters. A round-robin
// arbiter admits at most one argument per clock into the ROM, and a
// {valid, channel} tag pipeline of LATENCY stages runs beside the ROM so that
// every result leaves tagged with the channel that asked for it. The ROM clock
// enable doubles as the backpressure control, so ROM data and tags stall
// together.
//
// Ports
//   clk        : clock
//   reset      : asynchronous reset, active-low
//   req_valid  : per-channel request valid
//   req_arg    : per-channel argument, channel i at [i*WIDTH +: WIDTH]
//   req_ready  : per-channel accept, one-hot or zero
//   rom_clkena : ROM clock enable (pipeline advance)
//   rom_arg    : argument presented to the ROM
//   rom_sin    : ROM sine output
//   rom_cos    : ROM cosine output
//   res_valid  : result valid
//   res_ready  : downstream accept
//   res_chan   : channel id of the current result
//   res_sin    : sine result (ROM pass-through)
//   res_cos    : cosine result (ROM pass-through)
// -----------------------------------------------------------------------------
module alt_rom_sin_cos_arbiter #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int LATENCY  = 2,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CHANNELS-1:0]       req_valid,
  input  logic [CHANNELS*WIDTH-1:0] req_arg,
  output logic [CHANNELS-1:0]       req_ready,
  output logic                      rom_clkena,
  output logic [WIDTH-1:0]          rom_arg,
  input  logic [WIDTH-1:0]          rom_sin,
  input  logic [WIDTH-1:0]          rom_cos,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [CW-1:0]             res_chan,
  output logic [WIDTH-1:0]          res_sin,
  output logic [WIDTH-1:0]          res_cos
);

  typedef struct packed {
    logic          vld;
    logic [CW-1:0] chan;
  } tag_t;

  tag_t          tag_q [LATENCY];
  tag_t          tag_d [LATENCY];
  logic [CW-1:0] last_q, last_d;

  logic          adv;
  logic          found;
  logic [CW-1:0] grant;
  logic          transfer;

  // The pipeline may advance whenever the output slot is empty or being taken.
  assign adv        = ~res_valid | res_ready;
  assign rom_clkena = adv;

  // Round-robin search starting just after the last granted channel.
  always_comb begin
    int idx;
    // NOTE: every variable assigned here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int i = 0; i < CHANNELS; i++) begin
      idx = (int'(last_q) + 1 + i) % CHANNELS;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = CW'(idx);
      end
    end
  end

  // reset gates the accept so nothing is handed out while the block is held
  // in reset, even though adv is high then.
  always_comb begin
    req_ready = '0;
    rom_arg   = '0;
    transfer  = found & adv & reset;
    if (found) begin
      rom_arg = req_arg[int'(grant)*WIDTH +: WIDTH];
    end
    if (transfer) begin
      req_ready[grant] = 1'b1;
    end
  end

  // Tags shift only with the ROM so both stay aligned through stalls.
  always_comb begin
    tag_d  = tag_q;
    last_d = last_q;
    if (transfer) begin
      last_d = grant;
    end
    if (adv) begin
      tag_d[0].vld  = transfer;
      tag_d[0].chan = transfer ? grant : '0;
      for (int k = 1; k < LATENCY; k++) begin
        tag_d[k] = tag_q[k-1];
      end
    end
  end

  // NOTE: only the tags are reset, not the ROM data path; stale ROM contents
  // are harmless because vld=0 masks them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        tag_q[k] <= '0;
      end
      last_q <= CW'(CHANNELS - 1);
    end else begin
      // NOTE: state uses non-blocking assignments so every flop samples the
      // pre-edge value regardless of statement order.
      for (int k = 0; k < LATENCY; k++) begin
        tag_q[k] <= tag_d[k];
      end
      last_q <= last_d;
    end
  end

  assign res_valid = tag_q[LATENCY-1].vld;
  assign res_chan  = tag_q[LATENCY-1].chan;
  assign res_sin   = rom_sin;
  assign res_cos   = rom_cos;

endmodule

// File: tb/tb_alt_rom_sin_cos_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alt_rom_sin_cos_arbiter
// Directed bench for the ROM arbiter with a behavioural two-stage,
// clkena-gated ROM (sin = arg+1, cos = arg+2). Inputs change 1 time unit
// after the rising edge; outputs are sampled 1 time unit later.
// -----------------------------------------------------------------------------
module tb_alt_rom_sin_cos_arbiter;

  localparam int WIDTH    = 16;
  localparam int CHANNELS = 4;
  localparam int LATENCY  = 2;
  localparam int CW       = 2;

  logic                      clk;
  logic                      reset;
  logic [CHANNELS-1:0]       req_valid;
  logic [CHANNELS*WIDTH-1:0] req_arg;
  logic [CHANNELS-1:0]       req_ready;
  logic                      rom_clkena;
  logic [WIDTH-1:0]          rom_arg;
  logic [WIDTH-1:0]          rom_sin;
  logic [WIDTH-1:0]          rom_cos;
  logic                      res_valid;
  logic                      res_ready;
  logic [CW-1:0]             res_chan;
  logic [WIDTH-1:0]          res_sin;
  logic [WIDTH-1:0]          res_cos;

  int total;
  int bad;

  alt_rom_sin_cos_arbiter #(
    .WIDTH   (WIDTH),
    .CHANNELS(CHANNELS),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_arg   (req_arg),
    .req_ready (req_ready),
    .rom_clkena(rom_clkena),
    .rom_arg   (rom_arg),
    .rom_sin   (rom_sin),
    .rom_cos   (rom_cos),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_chan  (res_chan),
    .res_sin   (res_sin),
    .res_cos   (res_cos)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ROM: two enabled clocks from arg to output, no reset.
  logic [WIDTH-1:0] rom_p0, rom_p1;
  always @(posedge clk) begin
    if (rom_clkena) begin
      rom_p0 <= rom_arg;
      rom_p1 <= rom_p0;
    end
  end
  assign rom_sin = rom_p1 + 16'd1;
  assign rom_cos = rom_p1 + 16'd2;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    req_valid = '0;
    req_arg   = '0;
    res_ready = 1'b1;
    step();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req_valid = 4'b1111;
    req_arg   = '0;
    res_ready = 1'b1;
    #1;
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
    total++;
    if (res_chan !== 2'd0) begin bad++; $display("FAIL reset_res_chan got=%0d want=0", res_chan); end
    total++;
    if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_req_ready got=%b want=0000", req_ready); end
    step();
    step();
    req_valid = '0;
    reset     = 1'b1;
    #1;
    total++;
    if (rom_clkena !== 1'b1) begin bad++; $display("FAIL reset_clkena got=%b want=1", rom_clkena); end
  endtask

  task automatic test_single();
    do_reset();
    req_valid          = 4'b0100;
    req_arg[2*16 +: 16] = 16'h1234;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL single_grant got=%b want=0100", req_ready); end
    total++;
    if (rom_arg !== 16'h1234) begin bad++; $display("FAIL single_rom_arg got=%h want=1234", rom_arg); end
    step();
    req_valid = '0;
    #1;
    total++;
    if (req_ready !== 4'b0000 || res_valid !== 1'b0) begin
      bad++; $display("FAIL single_gap ready=%b valid=%b want 0000/0", req_ready, res_valid);
    end
    step();
    total++;
    if (res_valid !== 1'b1 || res_chan !== 2'd2 || res_sin !== 16'h1235 || res_cos !== 16'h1236) begin
      bad++;
      $display("FAIL single_result valid=%b chan=%0d sin=%h cos=%h want 1/2/1235/1236",
               res_valid, res_chan, res_sin, res_cos);
    end
    step();
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL single_after got=%b want=0", res_valid); end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int ch = 0; ch < CHANNELS; ch++) req_arg[ch*16 +: 16] = 16'(ch * 16'h100);
    for (int c = 0; c < 10; c++) begin
      logic [3:0]  exp_rdy;
      logic [1:0]  exp_ch;
      logic [15:0] exp_sin;
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      exp_rdy   = (c < 8) ? 4'(1 << (c % 4)) : 4'b0000;
      #1;
      total++;
      if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant c=%0d got=%b want=%b", c, req_ready, exp_rdy); end
      if (c >= 2) begin
        exp_ch  = 2'((c - 2) % 4);
        exp_sin = 16'(exp_ch) * 16'h100 + 16'd1;
        total++;
        if (res_valid !== 1'b1 || res_chan !== exp_ch || res_sin !== exp_sin || res_cos !== exp_sin + 16'd1) begin
          bad++;
          $display("FAIL rr_result c=%0d valid=%b chan=%0d sin=%h want 1/%0d/%h",
                   c, res_valid, res_chan, res_sin, exp_ch, exp_sin);
        end
      end
      step();
    end
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL rr_drain got=%b want=0", res_valid); end
  endtask

  task automatic test_backpressure();
    int          sent;
    int          recv;
    bit          held;
    logic [15:0] h_sin;
    logic [15:0] h_cos;
    logic [1:0]  h_chan;
    do_reset();
    sent = 0; recv = 0; held = 0; h_sin = '0; h_cos = '0; h_chan = '0;
    for (int cyc = 0; cyc < 100 && recv < 8; cyc++) begin
      req_valid        = (sent < 8) ? 4'b0001 : 4'b0000;
      req_arg[15:0]    = 16'(sent + 1);
      res_ready        = (cyc % 3 == 0);
      #1;
      if (held) begin
        total++;
        if (res_valid !== 1'b1 || res_sin !== h_sin || res_cos !== h_cos || res_chan !== h_chan) begin
          bad++;
          $display("FAIL bp_hold cyc=%0d valid=%b sin=%h cos=%h chan=%0d want 1/%h/%h/%0d",
                   cyc, res_valid, res_sin, res_cos, res_chan, h_sin, h_cos, h_chan);
        end
      end
      held = 1'b0;
      if (res_valid === 1'b1 && res_ready === 1'b0) begin
        total++;
        if (req_ready !== 4'b0000) begin bad++; $display("FAIL bp_stall_ready cyc=%0d got=%b want=0000", cyc, req_ready); end
        held = 1'b1; h_sin = res_sin; h_cos = res_cos; h_chan = res_chan;
      end
      if (res_valid === 1'b1 && res_ready === 1'b1) begin
        total++;
        if (res_sin !== 16'(recv + 2) || res_chan !== 2'd0) begin
          bad++; $display("FAIL bp_order n=%0d sin=%h chan=%0d want %h/0", recv, res_sin, res_chan, 16'(recv + 2));
        end
        recv++;
      end
      if (req_ready[0] === 1'b1) sent++;
      step();
    end
    total++;
    if (recv != 8) begin bad++; $display("FAIL bp_count got=%0d want=8", recv); end
    req_valid = '0;
    res_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (res_valid !== 1'b0) begin bad++; $display("FAIL bp_dup c=%0d got=%b want=0", c, res_valid); end
      step();
    end
  endtask

  task automatic test_fairness();
    do_reset();
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL fair_first got=%b want=0001", req_ready); end
    step();
    req_valid = 4'b1001;
    #1;
    total++;
    if (req_ready !== 4'b1000) begin bad++; $display("FAIL fair_ch3 got=%b want=1000", req_ready); end
    step();
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL fair_ch0_next got=%b want=0001", req_ready); end
    step();
    req_valid = '0;
    step();
    step();
  endtask

  task automatic test_reset_midflight();
    do_reset();
    req_valid = 4'b1111;
    step();
    step();
    req_valid = '0;
    reset     = 1'b0;
    #1;
    total++;
    if (res_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_valid got=%b want=0", res_valid); end
    step();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (res_valid !== 1'b0) begin bad++; $display("FAIL mid_reset_ghost c=%0d got=%b want=0", c, res_valid); end
      step();
    end
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_reset_grant got=%b want=0001", req_ready); end
    step();
    req_valid = '0;
  endtask

  task automatic test_withdrawn();
    do_reset();
    req_arg[15:0] = 16'h0010;
    req_arg[31:16] = 16'h0777;
    res_ready     = 1'b0;
    req_valid     = 4'b0001;
    step();
    req_valid = '0;
    step();
    req_valid = 4'b0010;
    #1;
    total++;
    if (res_valid !== 1'b1 || req_ready !== 4'b0000 || rom_clkena !== 1'b0) begin
      bad++; $display("FAIL wd_stall valid=%b ready=%b clkena=%b want 1/0000/0", res_valid, req_ready, rom_clkena);
    end
    step();
    req_valid = '0;
    res_ready = 1'b1;
    #1;
    total++;
    if (res_valid !== 1'b1 || res_chan !== 2'd0 || res_sin !== 16'h0011) begin
      bad++; $display("FAIL wd_result valid=%b chan=%0d sin=%h want 1/0/0011", res_valid, res_chan, res_sin);
    end
    step();
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (res_valid !== 1'b0) begin bad++; $display("FAIL wd_ghost c=%0d got=%b chan=%0d want=0", c, res_valid, res_chan); end
      step();
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    req_valid = '0;
    req_arg   = '0;
    res_ready = 1'b1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_fairness();
    test_reset_midflight();
    test_withdrawn();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
